mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one backing memory port between the instruction-fetch port and the data (MEM-stage) port of the 5-stage pipeline datapath.
- Sits between the datapath and the memory/cache.
- Grants one requester at a time using round-robin, and latches the granted request's address, data and byte enables.
- Routes the memory response back to the granted requester only, and flags a memory transaction that never completes.

Parameters:
- TIMEOUT, 1023: number of service cycles without mem_resp before the transaction is aborted; 0 disables the watchdog.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W-1 >= TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_read  in  1  fetch request, held until inst_resp
- inst_addr  in  32  fetch address
- inst_resp  out  1  one-cycle fetch completion pulse
- inst_rdata  out  32  fetch data, valid when inst_resp=1
- data_read  in  1  load request, held until data_resp
- data_write  in  1  store request, held until data_resp
- data_mbe  in  4  store byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_resp  out  1  one-cycle load/store completion pulse
- data_rdata  out  32  load data, valid when data_resp=1
- mem_read  out  1  backing read, held until mem_resp
- mem_write  out  1  backing write, held until mem_resp
- mem_mbe  out  4  backing byte enables
- mem_addr  out  32  backing address
- mem_wdata  out  32  backing write data
- mem_resp  in  1  backing completion pulse
- mem_rdata  in  32  backing read data
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=DATA (so instruction side wins first tie), counter=0, timeout_err=0.
  - mem_read, mem_write, mem_mbe, mem_addr, mem_wdata = 0.
  - inst_resp, data_resp = 0; inst_rdata, data_rdata = 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, sampled at the clock edge:
  - Only inst_read=1: go to SERVE_I.
  - Only data_read or data_write=1: go to SERVE_D.
  - Both sides requesting: grant the side not equal to last_grant.
  - No request: stay in IDLE.
- On grant:
  - Register mem_addr, mem_wdata and mem_mbe from the granted requester; last_grant updates.
  - Instruction grant: mem_mbe=4'b1111, mem_wdata=0.
  - mem_read/mem_write are registered and assert in the first cycle of the SERVE state; the earliest is 1 cycle after the request is sampled.
- SERVE_I: mem_read=1, mem_write=0.
- SERVE_D: mem_write=data_write latched at grant; mem_read is its complement.
  - data_read and data_write both set at grant is treated as a write.
- Latched fields are held stable for the whole transaction; requester input changes are ignored until the next grant.
- Completion:
  - In a SERVE state, mem_resp=1 drives that requester's resp=1 in the same cycle (combinational).
  - Its rdata = mem_rdata combinationally; the other requester's resp=0.
  - Next state is IDLE; mem_read/mem_write drop on the following cycle.
- Responses are never routed to the non-granted side.
- mem_resp while in IDLE is ignored.
- Requester protocol: a requester deasserts its request the cycle after its resp.
  - Because the arbiter passes through IDLE for one cycle after every transaction, a held request is re-granted as a new transaction; this is intended.
  - Minimum transaction spacing is therefore 1 idle cycle.
- Watchdog (TIMEOUT>0):
  - counter clears on grant and increments each SERVE cycle without mem_resp, saturating at its maximum.
  - When counter==TIMEOUT-1 and mem_resp=0: next state IDLE, timeout_err set (sticky until rst), no resp pulse to the requester.
  - mem_resp arriving in the same cycle as expiry completes normally; timeout_err is not set.
- With TIMEOUT=0 the block waits forever.
- rst asserted mid-transaction aborts immediately to reset values; no resp pulse is issued and a pending mem_resp is discarded.
- Throughput: one transaction per (memory latency + 1 idle cycle); no overlap or pipelining of backing requests.

Test Plan:
- Single fetch:
  - Stimulus: after reset, inst_read=1, inst_addr=0x60, memory responds after 3 cycles with mem_rdata=0x00000013.
  - Response: mem_read=1 with mem_addr=0x60 and mem_mbe=1111; inst_resp pulses once with inst_rdata=0x13; data_resp stays 0.
- Store:
  - Stimulus: data_write=1, data_addr=0x104, data_wdata=0xDEADBEEF, data_mbe=0100.
  - Response: mem_write=1, mem_addr=0x104, mem_wdata=0xDEADBEEF, mem_mbe=0100; data_resp one pulse; mem_read=0 throughout.
- Contention round-robin:
  - Stimulus: inst_read and data_read held continuously, memory latency 2.
  - Response: grant order is I, D, I, D; exactly 1 IDLE cycle between transactions; each resp routed only to its owner.
- Input stability:
  - Stimulus: data_addr changes from 0x200 to 0x300 during SERVE_D.
  - Response: mem_addr stays 0x200 until completion.
- Timeout:
  - Stimulus: TIMEOUT=4, inst_read=1, no mem_resp ever.
  - Response: 4 cycles of mem_read=1, then IDLE with timeout_err=1, inst_resp never asserted; timeout_err stays 1 until rst.
- Reset mid-operation:
  - Stimulus: assert rst during SERVE_D (async, between edges).
  - Response: mem_write drops immediately and all outputs take reset values; the first post-reset tie is granted to inst.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline ports, the arbiter and the backing memory.
// The master modport is the arbiter; the slave modport is the datapath plus memory side.
interface mem_port_arbiter_if;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;

    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        input  inst_read, inst_addr,
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        input  mem_resp, mem_rdata,
        output inst_resp, inst_rdata,
        output data_resp, data_rdata,
        output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );

    modport slave (
        output inst_read, inst_addr,
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        output mem_resp, mem_rdata,
        input  inst_resp, inst_rdata,
        input  data_resp, data_rdata,
        input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backing memory port between instruction fetch and data access.
// A granted request is latched for the whole transaction; a watchdog aborts one that never completes.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               timeout_err
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [3:0]        mem_mbe_q, mem_mbe_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic inst_req;
    logic data_req;
    logic serving;
    logic wd_expire;

    assign inst_req  = bus.inst_read;
    assign data_req  = bus.data_read | bus.data_write;
    assign serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
    // A response landing in the expiry cycle wins over the watchdog.
    assign wd_expire = (TIMEOUT != 0) && serving && !bus.mem_resp && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_D;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_mbe_q     <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_mbe_q     <= mem_mbe_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_mbe_d     = mem_mbe_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (inst_req && (!data_req || (last_grant_q == GRANT_D))) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    wd_cnt_d     = '0;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_mbe_d    = 4'b1111;
                    mem_addr_d   = bus.inst_addr;
                    mem_wdata_d  = '0;
                end else if (data_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    wd_cnt_d     = '0;
                    mem_read_d   = !bus.data_write;
                    mem_write_d  = bus.data_write;
                    mem_mbe_d    = bus.data_mbe;
                    mem_addr_d   = bus.data_addr;
                    mem_wdata_d  = bus.data_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else if (wd_expire) begin
                    state_d       = IDLE;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.inst_resp  = (state_q == SERVE_I) && bus.mem_resp;
    assign bus.data_resp  = (state_q == SERVE_D) && bus.mem_resp;
    assign bus.inst_rdata = bus.inst_resp ? bus.mem_rdata : '0;
    assign bus.data_rdata = bus.data_resp ? bus.mem_rdata : '0;

    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_mbe    = mem_mbe_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign timeout_err    = timeout_err_q;

endmodule
